// File: rtl/qoi_encoder.sv
// QOI image encoder: 24-bit RGB pixel stream in, complete QOI file out as
// 32-bit little-endian-packed words. Header, per-pixel ops and end marker
// all pass through one 8-byte staging buffer that feeds the output port.
//
// state  | meaning
// IDLE   | waiting for the first pixel of a frame (pixel not consumed)
// HEADER | staging the 14 header bytes
// PIXEL  | encoding pixels, emitting run/index/diff/luma/rgb ops
// TAIL   | staging the 8-byte end marker and draining the last word
module qoi_encoder (
  input  logic        clk,
  input  logic        rstn,
  output logic        i_tready,
  input  logic        i_tvalid,
  input  logic        i_tlast,
  input  logic [7:0]  i_R,
  input  logic [7:0]  i_G,
  input  logic [7:0]  i_B,
  input  logic [31:0] i_width,
  input  logic [31:0] i_height,
  input  logic        o_tready,
  output logic        o_tvalid,
  output logic        o_tlast,
  output logic [31:0] o_tdata,
  output logic [3:0]  o_tkeep
);

  typedef enum logic [1:0] {IDLE, HEADER, PIXEL, TAIL} state_t;
  state_t state, state_nxt;

  logic [7:0]  stg [8];
  logic [7:0]  stg_nxt [8];
  logic [3:0]  cnt, cnt_nxt, pop_n, base, src, dst;
  logic [31:0] width_q, height_q;
  logic [3:0]  hdr_idx, tail_idx;
  logic [7:0]  prev_r, prev_g, prev_b;
  logic [5:0]  run, run_inc, run_nxt;
  logic [23:0] idx_mem [64];
  logic [63:0] idx_vld;

  logic        tail_done, pop, pix_acc, hdr_push, tail_push;
  logic        same, is_index, is_diff, is_luma;
  logic [11:0] hsum;
  logic [5:0]  hash;
  logic [7:0]  dr, dg, db, dr2, dg2, db2, dg32, rg8, bg8;
  logic [7:0]  op_b [4];
  logic [2:0]  op_n;
  logic [7:0]  push_b [5];
  logic [2:0]  push_n;

  function automatic logic [7:0] hdr_byte(input logic [3:0] i, input logic [31:0] w,
                                          input logic [31:0] h);
    case (i)
      4'd0:    return 8'h71;
      4'd1:    return 8'h6F;
      4'd2:    return 8'h69;
      4'd3:    return 8'h66;
      4'd4:    return w[31:24];
      4'd5:    return w[23:16];
      4'd6:    return w[15:8];
      4'd7:    return w[7:0];
      4'd8:    return h[31:24];
      4'd9:    return h[23:16];
      4'd10:   return h[15:8];
      4'd11:   return h[7:0];
      4'd12:   return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  // The final word is the only one allowed to be short; it appears once the
  // whole end marker is staged and at most 4 bytes remain.
  assign tail_done = (tail_idx == 4'd8);
  assign o_tvalid  = (cnt >= 4'd4) || ((state == TAIL) && tail_done && (cnt != 4'd0));
  assign o_tlast   = (state == TAIL) && tail_done && (cnt != 4'd0) && (cnt <= 4'd4);
  assign pop       = o_tvalid && o_tready;
  assign pop_n     = !pop ? 4'd0 : (o_tlast ? cnt : 4'd4);
  // Occupancy once the departing word is removed; using it for admission
  // lets a pixel enter in the same cycle a full word leaves.
  assign base      = cnt - pop_n;
  assign i_tready  = (state == PIXEL) && (base <= 4'd3);
  assign pix_acc   = i_tvalid && i_tready;
  assign hdr_push  = (state == HEADER) && (base <= 4'd4);
  assign tail_push = (state == TAIL) && !tail_done && (base <= 4'd4);

  assign same     = ({i_R, i_G, i_B} == {prev_r, prev_g, prev_b});
  assign run_inc  = run + 6'd1;
  // 2805 mod 64 = 53 (alpha fixed at 255 contributes 11*255).
  assign hsum     = 12'd3 * {4'd0, i_R} + 12'd5 * {4'd0, i_G} + 12'd7 * {4'd0, i_B} + 12'd53;
  assign hash     = hsum[5:0];
  assign dr       = i_R - prev_r;
  assign dg       = i_G - prev_g;
  assign db       = i_B - prev_b;
  // Biased differences: a signed range check becomes an unsigned compare.
  assign dr2      = dr + 8'd2;
  assign dg2      = dg + 8'd2;
  assign db2      = db + 8'd2;
  assign dg32     = dg + 8'd32;
  assign rg8      = dr - dg + 8'd8;
  assign bg8      = db - dg + 8'd8;
  assign is_diff  = (dr2 < 8'd4) && (dg2 < 8'd4) && (db2 < 8'd4);
  assign is_luma  = (dg32 < 8'd64) && (rg8 < 8'd16) && (bg8 < 8'd16);
  assign is_index = idx_vld[hash] && (idx_mem[hash] == {i_R, i_G, i_B});
  assign run_nxt  = (same && !((run_inc == 6'd62) || i_tlast)) ? run_inc : 6'd0;

  // Output word: bytes past the staged count read as zero padding.
  always_comb begin
    o_tdata = '0;
    o_tkeep = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (o_tvalid && (4'(i) < cnt)) o_tdata[8*i +: 8] = stg[i];
    if (o_tvalid) begin
      if (o_tlast) begin
        case (cnt)
          4'd1:    o_tkeep = 4'b0001;
          4'd2:    o_tkeep = 4'b0011;
          4'd3:    o_tkeep = 4'b0111;
          default: o_tkeep = 4'b1111;
        endcase
      end else begin
        o_tkeep = 4'b1111;
      end
    end
  end

  // Op selection for a non-repeating pixel, in priority order.
  always_comb begin
    for (int k = 0; k < 4; k++) op_b[k] = 8'h00;
    op_n = 3'd0;
    if (is_index) begin
      op_b[0] = {2'b00, hash};
      op_n    = 3'd1;
    end else if (is_diff) begin
      op_b[0] = {2'b01, dr2[1:0], dg2[1:0], db2[1:0]};
      op_n    = 3'd1;
    end else if (is_luma) begin
      op_b[0] = {2'b10, dg32[5:0]};
      op_b[1] = {rg8[3:0], bg8[3:0]};
      op_n    = 3'd2;
    end else begin
      op_b[0] = 8'hFE;
      op_b[1] = i_R;
      op_b[2] = i_G;
      op_b[3] = i_B;
      op_n    = 3'd4;
    end
  end

  // Bytes appended to the staging buffer this cycle (at most 5).
  always_comb begin
    for (int k = 0; k < 5; k++) push_b[k] = 8'h00;
    push_n = 3'd0;
    if (hdr_push) begin
      for (int k = 0; k < 4; k++) push_b[k] = hdr_byte(hdr_idx + 4'(k), width_q, height_q);
      push_n = (hdr_idx == 4'd12) ? 3'd2 : 3'd4;
    end else if (tail_push) begin
      push_b[3] = (tail_idx == 4'd4) ? 8'h01 : 8'h00;
      push_n    = 3'd4;
    end else if (pix_acc) begin
      if (same) begin
        // A run closing on 62 and on i_tlast together still yields one byte.
        if ((run_inc == 6'd62) || i_tlast) begin
          push_b[0] = {2'b11, run};
          push_n    = 3'd1;
        end
      end else if (run != 6'd0) begin
        push_b[0] = {2'b11, run - 6'd1};
        for (int k = 0; k < 4; k++) push_b[k+1] = op_b[k];
        push_n = op_n + 3'd1;
      end else begin
        for (int k = 0; k < 4; k++) push_b[k] = op_b[k];
        push_n = op_n;
      end
    end
  end

  // Buffer update: drop the departing word, then append at the new fill level.
  always_comb begin
    src = 4'd0;
    dst = 4'd0;
    for (int i = 0; i < 8; i++) begin
      src        = 4'(i) + pop_n;
      stg_nxt[i] = (src < 4'd8) ? stg[src[2:0]] : 8'h00;
    end
    for (int k = 0; k < 5; k++) begin
      dst = base + 4'(k);
      if ((3'(k) < push_n) && (dst < 4'd8)) stg_nxt[dst[2:0]] = push_b[k];
    end
    cnt_nxt = base + {1'b0, push_n};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_tvalid) state_nxt = HEADER;
      HEADER:  if (hdr_push && (hdr_idx == 4'd12)) state_nxt = PIXEL;
      PIXEL:   if (pix_acc && i_tlast) state_nxt = TAIL;
      TAIL:    if (pop && o_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: staging buffer, frame counters and encoder context.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 8; i++) stg[i] <= 8'h00;
      cnt      <= 4'd0;
      width_q  <= '0;
      height_q <= '0;
      hdr_idx  <= 4'd0;
      tail_idx <= 4'd0;
      prev_r   <= 8'd0;
      prev_g   <= 8'd0;
      prev_b   <= 8'd0;
      run      <= 6'd0;
      idx_vld  <= '0;
    end else begin
      for (int i = 0; i < 8; i++) stg[i] <= stg_nxt[i];
      cnt <= cnt_nxt;
      if ((state == IDLE) && i_tvalid) begin
        width_q  <= i_width;
        height_q <= i_height;
        hdr_idx  <= 4'd0;
        tail_idx <= 4'd0;
        prev_r   <= 8'd0;
        prev_g   <= 8'd0;
        prev_b   <= 8'd0;
        run      <= 6'd0;
        idx_vld  <= '0;
      end
      if (hdr_push)  hdr_idx  <= hdr_idx + 4'd4;
      if (tail_push) tail_idx <= tail_idx + 4'd4;
      if (pix_acc) begin
        prev_r <= i_R;
        prev_g <= i_G;
        prev_b <= i_B;
        run    <= run_nxt;
        if (!same) idx_vld[hash] <= 1'b1;
      end
    end
  end

  // Colour index table contents; validity is tracked separately in idx_vld.
  always_ff @(posedge clk) begin
    if (pix_acc && !same) idx_mem[hash] <= {i_R, i_G, i_B};
  end

endmodule
